stage_id_param: RTL and testbench

- Parametrised instruction-decode stage for the 5-stage MIPS pipeline.
- Contains the register file with write-through bypass, ID-stage branch resolution with two-source forwarding, and load-use / branch-dependency hazard detection.
- Drives the ID/EX pipeline register, which supports enable, flush and bubble insertion, plus a saturating stall counter.
- Sits between the IF/ID latch and the EX stage. Control decode is external; a pre-decoded control bundle arrives on ctrlIn.

---
 rtl/stage_id_param.sv | 128 ++++++++++++
 tb/tb_stage_id_param.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/stage_id_param.sv
// stage_id_param: MIPS ID stage with bypassed regfile, ID-stage branch resolution,
// hazard detection, ID/EX latch and saturating stall counter.
// Optional STAGE_ID_REGDUMP_EN adds the flattened pre-bypass regDump output.
module stage_id_param #(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 32,
    parameter int REG_AW   = 5,
    parameter int CTRL_W   = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              flush,
    input  logic [REG_AW-1:0] rs,
    input  logic [REG_AW-1:0] rt,
    input  logic [REG_AW-1:0] rd,
    input  logic [4:0]        sa,
    input  logic [15:0]       immediate,
    input  logic [DATA_W-1:0] inPc,
    input  logic [CTRL_W-1:0] ctrlIn,
    input  logic              isBranch,
    input  logic              branchNe,
    input  logic              memReadEX,
    input  logic              regWriteEX,
    input  logic [REG_AW-1:0] regDestEX,
    input  logic              inRegWrite,
    input  logic [REG_AW-1:0] writeReg,
    input  logic [DATA_W-1:0] writeData,
    input  logic [DATA_W-1:0] aluOutExMem,
    input  logic [1:0]        fwdA,
    input  logic [1:0]        fwdB,
    output logic              stall,
    output logic              PCSrc,
    output logic [DATA_W-1:0] branchTarget,
    output logic [DATA_W-1:0] outPc,
    output logic [DATA_W-1:0] outDataRs,
    output logic [DATA_W-1:0] outDataRt,
    output logic [DATA_W-1:0] outImm,
    output logic [REG_AW-1:0] outRegRs,
    output logic [REG_AW-1:0] outRegRt,
    output logic [REG_AW-1:0] outRegRd,
    output logic [4:0]        outSa,
    output logic [CTRL_W-1:0] outCtrl,
    output logic              outValid,
`ifdef STAGE_ID_REGDUMP_EN
    output logic [NUM_REGS*DATA_W-1:0] regDump,
`endif
    output logic [15:0]       stallCount
);
    logic [DATA_W-1:0] r_regs [NUM_REGS];
    logic              w_wrEn;
    logic [DATA_W-1:0] w_rsData;
    logic [DATA_W-1:0] w_rtData;
    logic [DATA_W-1:0] w_opA;
    logic [DATA_W-1:0] w_opB;
    logic [DATA_W-1:0] w_imm;
    logic              w_depRs;
    logic              w_depRt;
    logic              w_bubble;

    // Register file reads with same-cycle WB bypass; x0 is hardwired zero
    always_comb begin
        w_wrEn   = inRegWrite && (writeReg != '0);
        w_rsData = (rs == '0) ? '0 : (w_wrEn && writeReg == rs) ? writeData : r_regs[rs];
        w_rtData = (rt == '0) ? '0 : (w_wrEn && writeReg == rt) ? writeData : r_regs[rt];
        w_imm    = {{(DATA_W-16){immediate[15]}}, immediate};
    end

    // Hazards and branch resolution on forwarded operands
    always_comb begin
        w_depRs      = (regDestEX != '0) && (regDestEX == rs);
        w_depRt      = (regDestEX != '0) && (regDestEX == rt);
        stall        = (memReadEX || (isBranch && regWriteEX)) && (w_depRs || w_depRt);
        w_opA        = (fwdA == 2'b01) ? aluOutExMem : (fwdA == 2'b10) ? writeData : w_rsData;
        w_opB        = (fwdB == 2'b01) ? aluOutExMem : (fwdB == 2'b10) ? writeData : w_rtData;
        PCSrc        = isBranch && !stall && (branchNe ? (w_opA != w_opB) : (w_opA == w_opB));
        branchTarget = inPc + (w_imm << 2);
        w_bubble     = flush || (enable && stall);
    end

    // Register file storage; reset clears every entry and blocks writes
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
        end else if (w_wrEn) begin
            r_regs[writeReg] <= writeData;
        end
    end

    // ID/EX latch: flush beats hold, hold beats stall bubble
    always_ff @(posedge clk or posedge reset) begin
        if (reset || w_bubble) begin
            outPc     <= '0;
            outDataRs <= '0;
            outDataRt <= '0;
            outImm    <= '0;
            outRegRs  <= '0;
            outRegRt  <= '0;
            outRegRd  <= '0;
            outSa     <= '0;
            outCtrl   <= '0;
            outValid  <= 1'b0;
        end else if (enable) begin
            outPc     <= inPc;
            outDataRs <= w_rsData;
            outDataRt <= w_rtData;
            outImm    <= w_imm;
            outRegRs  <= rs;
            outRegRt  <= rt;
            outRegRd  <= rd;
            outSa     <= sa;
            outCtrl   <= ctrlIn;
            outValid  <= 1'b1;
        end
    end

    // Saturating count of enabled stall cycles, also counted when flush wins
    always_ff @(posedge clk or posedge reset) begin
        if (reset) stallCount <= '0;
        else if (stall && enable && stallCount != 16'hFFFF) stallCount <= stallCount + 16'd1;
    end

`ifdef STAGE_ID_REGDUMP_EN
    for (genvar g = 0; g < NUM_REGS; g++) begin : g_dump
        assign regDump[g*DATA_W +: DATA_W] = r_regs[g];
    end
`endif
endmodule

// File: tb/tb_stage_id_param.sv
// tb_stage_id_param: directed checks of stage_id_param with hand-computed expectations.
module tb_stage_id_param;
    logic        clk = 1'b0;
    logic        reset, enable, flush;
    logic [4:0]  rs, rt, rd, sa;
    logic [15:0] immediate;
    logic [31:0] inPc;
    logic [15:0] ctrlIn;
    logic        isBranch, branchNe, memReadEX, regWriteEX;
    logic [4:0]  regDestEX, writeReg;
    logic        inRegWrite;
    logic [31:0] writeData, aluOutExMem;
    logic [1:0]  fwdA, fwdB;
    logic        stall, PCSrc;
    logic [31:0] branchTarget, outPc, outDataRs, outDataRt, outImm;
    logic [4:0]  outRegRs, outRegRt, outRegRd, outSa;
    logic [15:0] outCtrl;
    logic        outValid;
    logic [15:0] stallCount;
    int          passed = 0;
    int          total = 0;

    stage_id_param dut (
        .clk(clk), .reset(reset), .enable(enable), .flush(flush),
        .rs(rs), .rt(rt), .rd(rd), .sa(sa), .immediate(immediate), .inPc(inPc),
        .ctrlIn(ctrlIn), .isBranch(isBranch), .branchNe(branchNe),
        .memReadEX(memReadEX), .regWriteEX(regWriteEX), .regDestEX(regDestEX),
        .inRegWrite(inRegWrite), .writeReg(writeReg), .writeData(writeData),
        .aluOutExMem(aluOutExMem), .fwdA(fwdA), .fwdB(fwdB),
        .stall(stall), .PCSrc(PCSrc), .branchTarget(branchTarget),
        .outPc(outPc), .outDataRs(outDataRs), .outDataRt(outDataRt), .outImm(outImm),
        .outRegRs(outRegRs), .outRegRt(outRegRt), .outRegRd(outRegRd),
        .outSa(outSa), .outCtrl(outCtrl), .outValid(outValid), .stallCount(stallCount)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1; enable = 0; flush = 0; rs = 0; rt = 0; rd = 0; sa = 0;
        immediate = 0; inPc = 0; ctrlIn = 0; isBranch = 0; branchNe = 0;
        memReadEX = 0; regWriteEX = 0; regDestEX = 0; inRegWrite = 0;
        writeReg = 0; writeData = 0; aluOutExMem = 0; fwdA = 0; fwdB = 0;
        #1;
        chk("rst_valid", outValid, 0);
        chk("rst_count", stallCount, 0);
        chk("rst_pc", outPc, 0);
        tick();
        reset = 0;
        enable = 1; inRegWrite = 1; writeReg = 5; writeData = 32'hAA; rs = 5;
        inPc = 32'h40; ctrlIn = 16'h1234; immediate = 16'h8001; rd = 6; sa = 2;
        #1;
        chk("wb_nostall", stall, 0);
        tick();
        chk("bypass_rs", outDataRs, 32'hAA);
        chk("load_valid", outValid, 1);
        chk("load_ctrl", outCtrl, 16'h1234);
        chk("load_imm", outImm, 32'hFFFF8001);
        chk("load_pc", outPc, 32'h40);
        chk("load_rd", outRegRd, 6);
        writeReg = 0; writeData = 32'h55; rs = 0; rt = 5;
        tick();
        chk("x0_zero", outDataRs, 0);
        chk("rt_stored", outDataRt, 32'hAA);
        inRegWrite = 0; rs = 0; rt = 3; memReadEX = 1; regDestEX = 3;
        #1;
        chk("lu_stall", stall, 1);
        tick();
        chk("lu_valid", outValid, 0);
        chk("lu_ctrl", outCtrl, 0);
        chk("lu_count", stallCount, 1);
        rt = 4;
        #1;
        chk("lu_clear", stall, 0);
        memReadEX = 0; inRegWrite = 1; writeReg = 7; writeData = 32'h7;
        tick();
        inRegWrite = 0; isBranch = 1; branchNe = 0; fwdA = 2'b01; fwdB = 2'b00;
        aluOutExMem = 32'h7; rs = 1; rt = 7; inPc = 32'h100; immediate = 16'hFFFF;
        #1;
        chk("beq_taken", PCSrc, 1);
        chk("br_target", branchTarget, 32'hFC);
        branchNe = 1;
        #1;
        chk("bne_not", PCSrc, 0);
        branchNe = 0; fwdA = 2'b10; writeData = 32'h9;
        #1;
        chk("beq_wbfwd", PCSrc, 0);
        fwdA = 2'b00; rs = 2; rt = 2; regWriteEX = 1; regDestEX = 2;
        #1;
        chk("brdep_stall", stall, 1);
        chk("brdep_pcsrc", PCSrc, 0);
        tick();
        chk("brdep_count", stallCount, 2);
        isBranch = 0; regWriteEX = 0; regDestEX = 0; rs = 5; rt = 7; rd = 9; sa = 3;
        inPc = 32'h200; ctrlIn = 16'hABCD; immediate = 16'h0010;
        tick();
        chk("ld2_rs", outDataRs, 32'hAA);
        chk("ld2_rt", outDataRt, 32'h7);
        chk("ld2_imm", outImm, 32'h10);
        chk("ld2_sa", outSa, 3);
        enable = 0;
        for (int i = 0; i < 3; i++) begin
            rs = 5'(i + 10); ctrlIn = 16'(16'hF000 + i); inPc = 32'(32'h300 + i);
            tick();
            chk("hold_ctrl", outCtrl, 16'hABCD);
            chk("hold_pc", outPc, 32'h200);
            chk("hold_rs", outRegRs, 5);
        end
        flush = 1;
        tick();
        chk("flush_valid", outValid, 0);
        chk("flush_ctrl", outCtrl, 0);
        enable = 1; memReadEX = 1; regDestEX = 7; rt = 7;
        tick();
        chk("fs_valid", outValid, 0);
        chk("fs_count", stallCount, 3);
        flush = 0; memReadEX = 0; regDestEX = 0;
        tick();
        chk("pre_rst_valid", outValid, 1);
        #2;
        reset = 1;
        #1;
        chk("async_valid", outValid, 0);
        chk("async_pc", outPc, 0);
        chk("async_ctrl", outCtrl, 0);
        chk("async_count", stallCount, 0);
        inRegWrite = 1; writeReg = 5; writeData = 32'h123;
        tick();
        reset = 0; inRegWrite = 0; rs = 5;
        tick();
        chk("rf_cleared", outDataRs, 0);
        memReadEX = 1; regDestEX = 3; rt = 3;
        repeat (70000) @(posedge clk);
        #1;
        chk("sat_count", stallCount, 16'hFFFF);
        tick();
        chk("sat_nowrap", stallCount, 16'hFFFF);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
